// File: rtl/pia_bus_arbiter.sv
// Two-master arbiter for the PIA register bus: the CPU has priority, and a debug
// master uses free cycles or takes a forced slot once it has waited long enough.
module pia_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cpu_stb_i,
  input  logic       cpu_we_i,
  input  logic [6:0] cpu_adr_i,
  input  logic [7:0] cpu_dat_i,
  output logic [7:0] cpu_dat_o,
  output logic       cpu_rdy_o,
  input  logic       dbg_req_i,
  input  logic       dbg_we_i,
  input  logic [6:0] dbg_adr_i,
  input  logic [7:0] dbg_dat_i,
  output logic       dbg_ack_o,
  output logic [7:0] dbg_dat_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [6:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FORCE    = 2'd1,
    ST_DBG_DATA = 2'd2,
    ST_DBG_ACK  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [7:0]       dbg_dat_q, dbg_dat_d;
  logic             ack_q, ack_d;
  logic             rdy_q, rdy_d;
  logic             stb_s;

  assign cpu_dat_o = s_dat_i;
  assign cpu_rdy_o = rdy_q;
  assign dbg_ack_o = ack_q;
  assign dbg_dat_o = dbg_dat_q;
  assign s_stb_o   = stb_s & rst_ni;

  // Slave mux: debug fields only on an IDLE free-cycle issue or a forced slot.
  always_comb begin
    stb_s   = 1'b0;
    s_we_o  = cpu_we_i;
    s_adr_o = cpu_adr_i;
    s_dat_o = cpu_dat_i;
    case (state_q)
      ST_IDLE: begin
        if (cpu_stb_i) begin
          stb_s = 1'b1;
        end else if (dbg_req_i) begin
          stb_s   = 1'b1;
          s_we_o  = dbg_we_i;
          s_adr_o = dbg_adr_i;
          s_dat_o = dbg_dat_i;
        end else begin
          stb_s = 1'b0;
        end
      end
      ST_FORCE: begin
        stb_s   = 1'b1;
        s_we_o  = dbg_we_i;
        s_adr_o = dbg_adr_i;
        s_dat_o = dbg_dat_i;
      end
      ST_DBG_DATA, ST_DBG_ACK: begin
        stb_s = cpu_stb_i;
      end
      default: begin
        stb_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dbg_dat_d = dbg_dat_q;
    cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    case (state_q)
      ST_IDLE: begin
        if (dbg_req_i && !cpu_stb_i) begin
          state_d = ST_DBG_DATA;
          cnt_d   = '0;
        end else if (dbg_req_i) begin
          cnt_d = cnt_inc_s;
          // The blocked CPU access this cycle still goes through; the slot is stolen next cycle.
          if ((STARVE_LIMIT != 32'd0) && (cnt_inc_s == LIMIT)) begin
            state_d = ST_FORCE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_FORCE: begin
        state_d = ST_DBG_DATA;
        cnt_d   = '0;
      end
      ST_DBG_DATA: begin
        dbg_dat_d = s_dat_i;
        state_d   = ST_DBG_ACK;
      end
      ST_DBG_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    rdy_d = (state_d != ST_FORCE);
    ack_d = (state_d == ST_DBG_ACK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dbg_dat_q <= 8'h00;
      ack_q     <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dbg_dat_q <= dbg_dat_d;
      ack_q     <= ack_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pia_bus_arbiter.sv
// Bench for pia_bus_arbiter: directed scenarios plus random traffic, checked against
// a timeline model (issue cycle, ack two cycles later, blocked-cycle count).
module tb_pia_bus_arbiter;

  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_stb, cpu_we, dbg_req, dbg_we;
  logic [6:0] cpu_adr, dbg_adr;
  logic [7:0] cpu_dat, dbg_dat, s_dat;

  logic [7:0] a_cpu_dat, a_dbg_dat, a_s_dat;
  logic       a_rdy, a_ack, a_s_stb, a_s_we;
  logic [6:0] a_s_adr;
  logic [7:0] z_cpu_dat, z_dbg_dat, z_s_dat;
  logic       z_rdy, z_ack, z_s_stb, z_s_we;
  logic [6:0] z_s_adr;

  int vectors = 0;
  int miscompares = 0;

  int         cyc = 0;
  int         last_issue;
  bit         force_now;
  int         blocked;
  logic [7:0] dat_m;
  bit         ack_m;
  int         req_start;

  always #5 clk = ~clk;

  pia_bus_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat),
    .cpu_dat_o(a_cpu_dat), .cpu_rdy_o(a_rdy),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_adr_i(dbg_adr), .dbg_dat_i(dbg_dat),
    .dbg_ack_o(a_ack), .dbg_dat_o(a_dbg_dat),
    .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat),
    .s_dat_i(s_dat)
  );

  pia_bus_arbiter #(.STARVE_LIMIT(0), .CNT_W(8)) dut_z (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat),
    .cpu_dat_o(z_cpu_dat), .cpu_rdy_o(z_rdy),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_adr_i(dbg_adr), .dbg_dat_i(dbg_dat),
    .dbg_ack_o(z_ack), .dbg_dat_o(z_dbg_dat),
    .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_adr_o(z_s_adr), .s_dat_o(z_s_dat),
    .s_dat_i(s_dat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_issue = -100;
    force_now  = 1'b0;
    blocked    = 0;
    dat_m      = 8'h00;
  endtask

  // One clock cycle: compare dut_a against the model mid-cycle, then advance the model.
  task automatic tick();
    bit         in_flight, idle, issue, e_stb, e_we;
    logic [6:0] e_adr;
    logic [7:0] e_dat;
    @(negedge clk);
    in_flight = (cyc > last_issue) && (cyc <= last_issue + 2);
    idle      = !force_now && !in_flight;
    issue     = force_now || (idle && !cpu_stb && dbg_req);
    ack_m     = (cyc == last_issue + 2);
    if (issue) begin
      e_stb = 1'b1; e_we = dbg_we; e_adr = dbg_adr; e_dat = dbg_dat;
    end else begin
      e_stb = cpu_stb; e_we = cpu_we; e_adr = cpu_adr; e_dat = cpu_dat;
    end
    chk("s_stb", 32'(a_s_stb), 32'(e_stb & rst_n));
    if (rst_n) begin
      chk("s_we", 32'(a_s_we), 32'(e_we));
      chk("s_adr", 32'(a_s_adr), 32'(e_adr));
      chk("s_dat", 32'(a_s_dat), 32'(e_dat));
      chk("cpu_rdy", 32'(a_rdy), 32'(!force_now));
      chk("dbg_ack", 32'(a_ack), 32'(ack_m));
      chk("dbg_dat", 32'(a_dbg_dat), 32'(dat_m));
      chk("cpu_dat", 32'(a_cpu_dat), 32'(s_dat));
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cyc == last_issue + 1) dat_m = s_dat;
      if (force_now) begin
        last_issue = cyc; blocked = 0; force_now = 1'b0;
      end else if (idle) begin
        if (dbg_req && !cpu_stb) begin
          last_issue = cyc; blocked = 0;
        end else if (dbg_req) begin
          blocked = (blocked < 255) ? blocked + 1 : 255;
          if (LIM > 0 && blocked == LIM) force_now = 1'b1;
        end else begin
          blocked = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_adr = 7'h00; cpu_dat = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = 7'h00; dbg_dat = 8'h00;
    s_dat   = 8'h00;
  endtask

  initial begin
    model_reset();
    ack_m = 1'b0;
    req_start = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Debug write on a free bus: issue now, ack two cycles later.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 7'h01; dbg_dat = 8'hA5;
    #1;
    chk("t1_stb", 32'(a_s_stb), 32'd1);
    chk("t1_we", 32'(a_s_we), 32'd1);
    chk("t1_adr", 32'(a_s_adr), 32'h01);
    chk("t1_dat", 32'(a_s_dat), 32'hA5);
    tick();
    #1 chk("t1_ack_c1", 32'(a_ack), 32'd0);
    tick();
    #1 chk("t1_ack_c2", 32'(a_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    #1 chk("t1_ack_c3", 32'(a_ack), 32'd0);
    chk("t1_rdy_c3", 32'(a_rdy), 32'd1);
    tick();

    // Debug read: data returned by the slave the cycle after the strobe.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 7'h04; dbg_dat = 8'h00;
    tick();
    s_dat = 8'h3C;
    tick();
    s_dat = 8'h99;
    #1 chk("t2_ack", 32'(a_ack), 32'd1);
    chk("t2_dat", 32'(a_dbg_dat), 32'h3C);
    tick();
    dbg_req = 1'b0;
    #1 chk("t2_dat_held", 32'(a_dbg_dat), 32'h3C);
    tick();

    // CPU busy for three cycles, debug slips into the first free one.
    cpu_we = 1'b0; cpu_adr = 7'h10; cpu_dat = 8'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 7'h22; dbg_dat = 8'h33;
    for (int c = 0; c <= 5; c++) begin
      cpu_stb = (c != 3);
      #1;
      chk("t3_adr", 32'(a_s_adr), (c == 3) ? 32'h22 : 32'h10);
      chk("t3_rdy", 32'(a_rdy), 32'd1);
      chk("t3_ack", 32'(a_ack), (c == 5) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs();
    tick();

    // Starvation: CPU never idle, slot forced after LIM blocked cycles, then again.
    cpu_stb = 1'b1; cpu_adr = 7'h15; cpu_dat = 8'h51;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 7'h6A; dbg_dat = 8'hC3;
    for (int c = 0; c <= 13; c++) begin
      #1;
      chk("t4_rdy", 32'(a_rdy), (c == 4 || c == 11) ? 32'd0 : 32'd1);
      chk("t4_adr", 32'(a_s_adr), (c == 4 || c == 11) ? 32'h6A : 32'h15);
      chk("t4_ack", 32'(a_ack), (c == 6 || c == 13) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs();
    tick();

    // Reset in the middle of a debug read: no ack, data register cleared.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 7'h05;
    tick();
    rst_n = 1'b0; cpu_stb = 1'b1; s_dat = 8'h77;
    #1 chk("t5_stb_rst", 32'(a_s_stb), 32'd0);
    tick();
    rst_n = 1'b1; dbg_req = 1'b0; cpu_stb = 1'b0;
    #1 chk("t5_rdy", 32'(a_rdy), 32'd1);
    chk("t5_ack", 32'(a_ack), 32'd0);
    chk("t5_dat", 32'(a_dbg_dat), 32'h00);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1 chk("t5_no_ack", 32'(a_ack), 32'd0);
      tick();
    end

    // Forcing disabled: the debug master waits forever, counter saturates.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cpu_stb = 1'b1; cpu_adr = 7'h11; cpu_dat = 8'h22;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 7'h6E; dbg_dat = 8'h44;
    for (int c = 0; c < 300; c++) begin
      #1;
      chk("t6_z_rdy", 32'(z_rdy), 32'd1);
      chk("t6_z_adr", 32'(z_s_adr), 32'h11);
      chk("t6_z_ack", 32'(z_ack), 32'd0);
      tick();
    end
    chk("t6_z_cnt", 32'(dut_z.cnt_q), 32'd255);
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic; debug fields held stable from request until ack.
    for (int i = 0; i < 1500; i++) begin
      cpu_stb = ($urandom_range(0, 3) != 0);
      cpu_we  = 1'($urandom_range(0, 1));
      cpu_adr = 7'($urandom_range(0, 127));
      cpu_dat = 8'($urandom_range(0, 255));
      s_dat   = 8'($urandom_range(0, 255));
      if (!dbg_req || ack_m) begin
        if ($urandom_range(0, 2) == 0 || (dbg_req && ack_m && $urandom_range(0, 1) == 0)) begin
          dbg_req = 1'b1;
          req_start = cyc;
        end else begin
          dbg_req = 1'b0;
        end
        dbg_we  = 1'($urandom_range(0, 1));
        dbg_adr = 7'($urandom_range(0, 127));
        dbg_dat = 8'($urandom_range(0, 255));
      end else if (!force_now && last_issue < req_start && $urandom_range(0, 15) == 0) begin
        dbg_req = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pia_bus_arbiter.md
Name: pia_bus_arbiter

Overview:
- Shares the PIA register bus (strobe / write-enable / 7-bit address / 8-bit data) between two masters: the 6502 CPU core and a debug master (OSD/ESP32 register poker).
- CPU has priority. Debug accesses use free cycles, and a starvation timer can force a slot by deasserting the CPU's RDY for one cycle.
- Sits between the CPU bus decode and the PIA instance. The slave's read data is registered, so it is valid the cycle after the strobe.

Parameters:
- STARVE_LIMIT, 16: number of blocked debug-pending cycles before a slot is forced; 0 disables forcing.
- CNT_W, 8: width of the starvation counter; STARVE_LIMIT must be below 2^CNT_W.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_ni  in  1  synchronous reset, active low.
- cpu_stb_i  in  1  CPU access strobe for the PIA region.
- cpu_we_i  in  1  CPU write enable.
- cpu_adr_i  in  7  CPU register address.
- cpu_dat_i  in  8  CPU write data.
- cpu_dat_o  out  8  CPU read data; combinational pass-through of s_dat_i.
- cpu_rdy_o  out  1  CPU RDY; low means the CPU access in this cycle is not forwarded and must be repeated.
- dbg_req_i  in  1  debug request; held high with fields stable until dbg_ack_o.
- dbg_we_i  in  1  debug write enable.
- dbg_adr_i  in  7  debug address.
- dbg_dat_i  in  8  debug write data.
- dbg_ack_o  out  1  one-cycle completion pulse.
- dbg_dat_o  out  8  debug read data, registered; valid from ack and held until the next ack.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  7  slave address.
- s_dat_o  out  8  slave write data.
- s_dat_i  in  8  slave read data; valid one cycle after its strobe.

Behaviour:
- States: IDLE, FORCE, DBG_DATA, DBG_ACK. Registered state drives a combinational slave mux.
- IDLE, forwarding:
  - If cpu_stb_i=1, forward the CPU fields to the slave.
  - Else if dbg_req_i=1, forward the debug fields and go to DBG_DATA.
  - Else s_stb_o=0 (address/data still follow the CPU inputs).
- IDLE, starvation counting:
  - The counter increments (saturating) each IDLE cycle with dbg_req_i=1 and cpu_stb_i=1.
  - If STARVE_LIMIT>0 and the incremented value equals STARVE_LIMIT, go to FORCE. That cycle's CPU access is still forwarded.
- FORCE:
  - cpu_rdy_o=0 and cpu_stb_i is ignored.
  - The debug fields are forwarded with s_stb_o=1; go to DBG_DATA.
- DBG_DATA:
  - cpu_rdy_o=1 and CPU accesses are forwarded normally.
  - Capture s_dat_i into dbg_dat_o for both reads and writes; go to DBG_ACK.
- DBG_ACK:
  - dbg_ack_o=1 for this cycle only; CPU accesses are forwarded.
  - No debug issue in this cycle; dbg_req_i here is ignored.
  - Go to IDLE.
- Counter clears on every debug issue (IDLE issue or FORCE).
- Latency: debug issued in cycle n gives ack in n+2, so one debug access completes per 3 cycles at most. CPU latency is zero except for the forced cycle.
- cpu_rdy_o is 1 in every state except FORCE, so it is low for exactly one cycle per forced slot.
- A debug request that is withdrawn before issue is dropped silently and the counter clears.
- dbg_req_i still high in the cycle after ack starts a new transaction.
- Reset (rst_ni=0 at a clock edge), including mid-transaction:
  - State goes to IDLE, counter=0, dbg_dat_o=0x00, dbg_ack_o=0, cpu_rdy_o=1.
  - s_stb_o is gated to 0 while rst_ni=0.
  - An in-flight debug access is not acked.

Test Plan:
- CPU idle; debug write adr 0x01, dat 0xA5 in cycle 0 → cycle 0: s_stb_o=1, s_we_o=1, s_adr_o=0x01, s_dat_o=0xA5; cycle 2: dbg_ack_o=1; cycle 3: ack 0, state IDLE.
- Debug read adr 0x04 issued cycle 0, slave drives s_dat_i=0x3C in cycle 1 → cycle 2: dbg_ack_o=1, dbg_dat_o=0x3C, held after ack.
- cpu_stb_i=1 in cycles 0-2, low in cycle 3, dbg_req_i high throughout → slave carries CPU fields in cycles 0-2, debug fields in cycle 3; cpu_rdy_o stays 1; ack in cycle 5.
- STARVE_LIMIT=4, cpu_stb_i always 1, dbg_req_i from cycle 0 → cycles 0-3 forward CPU; cycle 4: cpu_rdy_o=0 with debug fields on the slave; cycle 6: ack; counter restarts.
- STARVE_LIMIT=0 with the same stimulus for 300 cycles → cpu_rdy_o never 0, no debug issue, counter saturates at 255.
- rst_ni=0 during DBG_DATA → next cycle: IDLE, no ack ever, dbg_dat_o=0x00, s_stb_o=0 while in reset.
